// File: rtl/muxnx1_rr_stream_pkg.sv
// Shared helpers for the round-robin N:1 stream multiplexer.
// Provides index-width and wrapping-increment functions plus default sizes.
package muxnx1_pkg;

  localparam int DEF_N     = 4;
  localparam int DEF_WIDTH = 8;

  // Bits needed to index v distinct channels (v >= 2).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/muxnx1_rr_stream_pick.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping modulo N.
// Produces the winner both one-hot and as an index, plus an any-request flag.
module rr_priority_pick
  import muxnx1_pkg::*;
#(
  parameter int  N     = DEF_N,
  localparam int SEL_W = clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     gnt_onehot,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

  int idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    idx        = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx]) begin
        any             = 1'b1;
        gnt_onehot[idx] = 1'b1;
        gnt_idx         = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/muxnx1_rr_stream.sv
// N:1 valid/ready stream multiplexer with round-robin source choice and one output register.
// Build option MUXNX1_STICKY_EN: the winning channel keeps priority while it stays valid.
module muxnx1_rr_stream
  import muxnx1_pkg::*;
#(
  parameter int  N     = DEF_N,
  parameter int  WIDTH = DEF_WIDTH,
  localparam int SEL_W = clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  input  logic               out_ready
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_nxt;
  logic [N-1:0]     gnt_onehot;
  logic [SEL_W-1:0] gnt_idx;
  logic             any;
  logic             load_ok;
  logic             in_xfer;
  logic [WIDTH-1:0] data_p0;

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic [SEL_W-1:0] sel_p1;

  rr_priority_pick #(.N(N)) u_pick (
    .req        (in_valid),
    .ptr        (ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any)
  );

  // Stage p0: grant, handshake and winner data select.
  always_comb begin
    load_ok  = !vld_p1 || out_ready;
    in_xfer  = load_ok && any && !rst;
    in_ready = in_xfer ? gnt_onehot : '0;
    data_p0  = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_onehot[i]) data_p0 = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
`ifdef MUXNX1_STICKY_EN
    ptr_nxt = gnt_idx;
`else
    ptr_nxt = SEL_W'(rr_next(int'(gnt_idx), N));
`endif
  end

  // Stage p1: output register and arbitration pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      sel_p1  <= '0;
      ptr     <= '0;
    end else if (in_xfer) begin
      vld_p1  <= 1'b1;
      data_p1 <= data_p0;
      sel_p1  <= gnt_idx;
      ptr     <= ptr_nxt;
    end else if (vld_p1 && out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_sel   = sel_p1;

endmodule

// File: tb/tb_muxnx1_rr_stream.sv
// Directed self-checking bench for muxnx1_rr_stream (N=4, WIDTH=8).
// Expected grant sequences differ per build; MUXNX1_STICKY_EN selects the matching tables.
module tb_muxnx1_rr_stream;

  logic        clk;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  int total;
  int bad;

`ifdef MUXNX1_STICKY_EN
  int rr_sel[8]       = '{0, 0, 0, 0, 0, 0, 0, 0};
  logic [3:0] sp_setup = 4'b1000;
  int sp_setup_sel     = 3;
  int sp_sel[3]       = '{0, 0, 0};
  int bp_sel[3]       = '{0, 0, 0};
  int st_sel[5]       = '{0, 0, 0, 1, 1};
`else
  int rr_sel[8]       = '{0, 1, 2, 3, 0, 1, 2, 3};
  logic [3:0] sp_setup = 4'b0100;
  int sp_setup_sel     = 2;
  int sp_sel[3]       = '{0, 2, 0};
  int bp_sel[3]       = '{1, 2, 3};
  int st_sel[5]       = '{1, 2, 3, 1, 2};
`endif

  muxnx1_rr_stream #(.N(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [7:0] base);
    for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = 8'(base + 8'(i));
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 4'hF; out_ready = 1'b1; set_data(8'hA0);
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0 || in_ready !== 4'h0) begin
        bad++;
        $display("FAIL reset cyc%0d: got v=%b d=%h s=%0d rdy=%b, want v=0 d=00 s=0 rdy=0000",
                 c, out_valid, out_data, out_sel, in_ready);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] ed;
    logic [3:0] er;
    rst = 1'b0; in_valid = 4'hF; out_ready = 1'b1; set_data(8'hA0);
    for (int k = 0; k < 8; k++) begin
      #1;
      er = 4'(1 << rr_sel[k]);
      total++;
      if (in_ready !== er) begin
        bad++;
        $display("FAIL rr_ready k=%0d: got %b want %b", k, in_ready, er);
      end
      tick();
      ed = 8'(8'hA0 + 8'(rr_sel[k]));
      total++;
      if (out_valid !== 1'b1 || out_sel !== 2'(rr_sel[k]) || out_data !== ed) begin
        bad++;
        $display("FAIL rr_out k=%0d: got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                 k, out_valid, out_sel, out_data, rr_sel[k], ed);
      end
    end
    in_valid = 4'h0;
    #1;
    total++;
    if (in_ready !== 4'h0) begin
      bad++;
      $display("FAIL rr_idle_ready: got %b want 0000", in_ready);
    end
    tick();
    ed = 8'(8'hA0 + 8'(rr_sel[7]));
    total++;
    if (out_valid !== 1'b0 || out_data !== ed || out_sel !== 2'(rr_sel[7])) begin
      bad++;
      $display("FAIL rr_drain: got v=%b d=%h s=%0d want v=0 d=%h s=%0d",
               out_valid, out_data, out_sel, ed, rr_sel[7]);
    end
  endtask

  task automatic test_sparse_wrap();
    logic [7:0] ed;
    logic [3:0] er;
    set_data(8'hB0); in_valid = sp_setup; out_ready = 1'b1;
    tick();
    total++;
    if (out_sel !== 2'(sp_setup_sel) || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL sparse_setup: got v=%b s=%0d want v=1 s=%0d", out_valid, out_sel, sp_setup_sel);
    end
    in_valid = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      #1;
      er = 4'(1 << sp_sel[k]);
      total++;
      if (in_ready !== er) begin
        bad++;
        $display("FAIL sparse_ready k=%0d: got %b want %b", k, in_ready, er);
      end
      tick();
      ed = 8'(8'hB0 + 8'(sp_sel[k]));
      total++;
      if (out_valid !== 1'b1 || out_sel !== 2'(sp_sel[k]) || out_data !== ed) begin
        bad++;
        $display("FAIL sparse_out k=%0d: got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                 k, out_valid, out_sel, out_data, sp_sel[k], ed);
      end
    end
    in_valid = 4'h0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] ed;
    logic [3:0] er;
    set_data(8'hC0); in_valid = 4'hF; out_ready = 1'b1;
    #1;
    er = 4'(1 << bp_sel[0]);
    total++;
    if (in_ready !== er) begin
      bad++;
      $display("FAIL bp_first_ready: got %b want %b", in_ready, er);
    end
    tick();
    out_ready = 1'b0;
    set_data(8'hD0);
    ed = 8'(8'hC0 + 8'(bp_sel[0]));
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (in_ready !== 4'h0) begin
        bad++;
        $display("FAIL bp_stall_ready c=%0d: got %b want 0000", c, in_ready);
      end
      tick();
      total++;
      if (out_valid !== 1'b1 || out_sel !== 2'(bp_sel[0]) || out_data !== ed) begin
        bad++;
        $display("FAIL bp_hold c=%0d: got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                 c, out_valid, out_sel, out_data, bp_sel[0], ed);
      end
    end
    out_ready = 1'b1;
    for (int k = 1; k < 3; k++) begin
      #1;
      er = 4'(1 << bp_sel[k]);
      total++;
      if (in_ready !== er) begin
        bad++;
        $display("FAIL bp_resume_ready k=%0d: got %b want %b", k, in_ready, er);
      end
      tick();
      ed = 8'(8'hD0 + 8'(bp_sel[k]));
      total++;
      if (out_valid !== 1'b1 || out_sel !== 2'(bp_sel[k]) || out_data !== ed) begin
        bad++;
        $display("FAIL bp_resume k=%0d: got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                 k, out_valid, out_sel, out_data, bp_sel[k], ed);
      end
    end
    in_valid = 4'h0;
    tick();
    total++;
    if (out_valid !== 1'b0 || out_sel !== 2'(bp_sel[2]) || out_data !== ed) begin
      bad++;
      $display("FAIL bp_drain: got v=%b s=%0d d=%h want v=0 s=%0d d=%h",
               out_valid, out_sel, out_data, bp_sel[2], ed);
    end
  endtask

  task automatic test_reset_mid_stream();
    set_data(8'hE0); in_valid = 4'b0010; out_ready = 1'b0;
    #1;
    total++;
    if (in_ready !== 4'b0010) begin
      bad++;
      $display("FAIL rmid_ready: got %b want 0010", in_ready);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 8'hE1) begin
      bad++;
      $display("FAIL rmid_load: got v=%b s=%0d d=%h want v=1 s=1 d=e1", out_valid, out_sel, out_data);
    end
    in_valid = 4'hF; rst = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0 || out_sel !== 2'd0 || out_data !== 8'h00 || in_ready !== 4'h0) begin
      bad++;
      $display("FAIL rmid_reset: got v=%b s=%0d d=%h rdy=%b want v=0 s=0 d=00 rdy=0000",
               out_valid, out_sel, out_data, in_ready);
    end
    rst = 1'b0; out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 4'b0001) begin
      bad++;
      $display("FAIL rmid_first_grant: got %b want 0001", in_ready);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 8'hE0) begin
      bad++;
      $display("FAIL rmid_first_out: got v=%b s=%0d d=%h want v=1 s=0 d=e0", out_valid, out_sel, out_data);
    end
    in_valid = 4'h0;
    tick();
  endtask

  task automatic test_sticky();
    logic [7:0] ed;
    logic [3:0] er;
    set_data(8'hF0); in_valid = 4'hF; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) in_valid = 4'b1110;
      #1;
      er = 4'(1 << st_sel[k]);
      total++;
      if (in_ready !== er) begin
        bad++;
        $display("FAIL sticky_ready k=%0d: got %b want %b", k, in_ready, er);
      end
      tick();
      ed = 8'(8'hF0 + 8'(st_sel[k]));
      total++;
      if (out_valid !== 1'b1 || out_sel !== 2'(st_sel[k]) || out_data !== ed) begin
        bad++;
        $display("FAIL sticky_out k=%0d: got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                 k, out_valid, out_sel, out_data, st_sel[k], ed);
      end
    end
    in_valid = 4'h0;
    tick();
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; in_valid = 4'h0; in_data = '0; out_ready = 1'b1;
    test_reset();
    test_round_robin();
    test_sparse_wrap();
    test_backpressure();
    test_reset_mid_stream();
    test_sticky();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
